// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
//  Module   : execute_unit
//  Brief    : Execute stage feeding the 8x8 register file writeback port.
//             Single-cycle ALU ops plus an iterative shift-add signed MUL.
//  Revision : 1.0 - initial release
// ============================================================================
module execute_unit #(
    parameter int MUL_STEPS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    input  logic [7:0] src_a,
    input  logic [7:0] src_b,
    input  logic [2:0] dst,
    output logic       wb_en,
    output logic [2:0] wb_reg,
    output logic [7:0] wb_data,
    output logic       ovf
);

    localparam int                 c_CNT_W  = $clog2(MUL_STEPS);
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(MUL_STEPS - 1);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLT = 3'b101;
    localparam logic [2:0] c_OP_MUL = 3'b110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [15:0]        r_acc;
    logic [15:0]        r_mcand;
    logic [8:0]         r_mplier;
    logic               r_sign;
    logic [2:0]         r_dst;
    logic               r_wb_en;
    logic [2:0]         r_wb_reg;
    logic [7:0]         r_wb_data;
    logic               r_ovf;

    logic [8:0]         w_add;
    logic [8:0]         w_sub;
    logic [8:0]         w_mag_a;
    logic [8:0]         w_mag_b;
    logic [15:0]        w_step_acc;
    logic [15:0]        w_prod;
    logic               w_mul_ovf;

    // 9-bit sums: the extra bit exposes signed overflow and lets -128 negate to +128
    assign w_add   = {src_a[7], src_a} + {src_b[7], src_b};
    assign w_sub   = {src_a[7], src_a} - {src_b[7], src_b};
    assign w_mag_a = src_a[7] ? (9'd0 - {src_a[7], src_a}) : {1'b0, src_a};
    assign w_mag_b = src_b[7] ? (9'd0 - {src_b[7], src_b}) : {1'b0, src_b};

    assign w_step_acc = r_acc + (r_mplier[0] ? r_mcand : 16'd0);
    assign w_prod     = r_sign ? (16'd0 - w_step_acc) : w_step_acc;
    // Fits in 8 signed bits only when bits 15..7 are all equal
    assign w_mul_ovf  = ~((&w_prod[15:7]) | ~(|w_prod[15:7]));

    assign in_ready = (r_state == S_IDLE);
    assign wb_en    = r_wb_en;
    assign wb_reg   = r_wb_reg;
    assign wb_data  = r_wb_data;
    assign ovf      = r_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_sign    <= 1'b0;
            r_dst     <= '0;
            r_wb_en   <= 1'b0;
            r_wb_reg  <= '0;
            r_wb_data <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_wb_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        case (op)
                            c_OP_ADD: begin
                                r_wb_en   <= 1'b1;
                                r_wb_reg  <= dst;
                                r_wb_data <= w_add[7:0];
                                r_ovf     <= w_add[8] ^ w_add[7];
                            end
                            c_OP_SUB: begin
                                r_wb_en   <= 1'b1;
                                r_wb_reg  <= dst;
                                r_wb_data <= w_sub[7:0];
                                r_ovf     <= w_sub[8] ^ w_sub[7];
                            end
                            c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_SLT: begin
                                r_wb_en  <= 1'b1;
                                r_wb_reg <= dst;
                                r_ovf    <= 1'b0;
                                case (op)
                                    c_OP_AND: r_wb_data <= src_a & src_b;
                                    c_OP_OR:  r_wb_data <= src_a | src_b;
                                    c_OP_XOR: r_wb_data <= src_a ^ src_b;
                                    default:  r_wb_data <= {7'd0, $signed(src_a) < $signed(src_b)};
                                endcase
                            end
                            c_OP_MUL: begin
                                r_state  <= S_MUL;
                                r_count  <= '0;
                                r_acc    <= '0;
                                r_mcand  <= {7'd0, w_mag_a};
                                r_mplier <= w_mag_b;
                                r_sign   <= src_a[7] ^ src_b[7];
                                r_dst    <= dst;
                            end
                            default: ; // NOP: accepted, no writeback
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc    <= w_step_acc;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        r_state   <= S_IDLE;
                        r_wb_en   <= 1'b1;
                        r_wb_reg  <= r_dst;
                        r_wb_data <= w_prod[7:0];
                        r_ovf     <= w_mul_ovf;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_unit
//  Brief    : Randomized + directed bench for execute_unit against an
//             integer-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_execute_unit;

    localparam int c_MUL_STEPS = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] src_a;
    logic [7:0] src_b;
    logic [2:0] dst;
    logic       wb_en;
    logic [2:0] wb_reg;
    logic [7:0] wb_data;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_busy;
    logic       m_en;
    logic [2:0] m_reg;
    logic [7:0] m_data;
    logic       m_ovf;
    logic [2:0] p_reg;
    logic [7:0] p_data;
    logic       p_ovf;

    execute_unit #(.MUL_STEPS(c_MUL_STEPS)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .dst      (dst),
        .wb_en    (wb_en),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic ref_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] d, output logic v);
        int x, y, r;
        x = $signed(a);
        y = $signed(b);
        case (o)
            3'd0:    r = x + y;
            3'd1:    r = x - y;
            3'd2:    r = int'(a & b);
            3'd3:    r = int'(a | b);
            3'd4:    r = int'(a ^ b);
            3'd5:    r = (x < y) ? 1 : 0;
            3'd6:    r = x * y;
            default: r = 0;
        endcase
        d = r[7:0];
        v = (o == 3'd0 || o == 3'd1 || o == 3'd6) && (r > 127 || r < -128);
    endtask

    task automatic model_clear();
        m_busy = 0; m_en = 0; m_reg = '0; m_data = '0; m_ovf = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        m_en = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_en = 1'b1; m_reg = p_reg; m_data = p_data; m_ovf = p_ovf;
            end
        end else if (in_valid) begin
            if (op == 3'd6) begin
                m_busy = c_MUL_STEPS;
                p_reg  = dst;
                ref_op(op, src_a, src_b, p_data, p_ovf);
            end else if (op != 3'd7) begin
                m_en  = 1'b1;
                m_reg = dst;
                ref_op(op, src_a, src_b, m_data, m_ovf);
            end
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 16'(in_ready), 16'(m_busy == 0));
        chk("wb_en",    16'(wb_en),    16'(m_en));
        chk("wb_reg",   16'(wb_reg),   16'(m_reg));
        chk("wb_data",  16'(wb_data),  16'(m_data));
        chk("ovf",      16'(ovf),      16'(m_ovf));
    endtask

    task automatic cycle(input logic v, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] d);
        in_valid = v; op = o; src_a = a; src_b = b; dst = d;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd7, 8'd0, 8'd0, 3'd0);
    endtask

    function automatic logic [7:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'hFF;
            2:       return 8'h00;
            3:       return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0;
        model_clear();
        p_reg = '0; p_data = '0; p_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // Signed overflow on ADD and SUB
        cycle(1'b1, 3'd0, 8'd100, 8'd50, 3'd3);
        cycle(1'b1, 3'd1, 8'h80, 8'd1, 3'd1);
        // Back-to-back logic ops and SLT
        cycle(1'b1, 3'd2, 8'hF0, 8'h3C, 3'd2);
        cycle(1'b1, 3'd3, 8'hF0, 8'h3C, 3'd4);
        cycle(1'b1, 3'd4, 8'hF0, 8'h3C, 3'd6);
        cycle(1'b1, 3'd5, 8'hFB, 8'd3, 3'd7);
        // NOP after ADD holds the ADD results
        cycle(1'b1, 3'd0, 8'd5, 8'd6, 3'd2);
        cycle(1'b1, 3'd7, 8'd9, 8'd9, 3'd5);
        run_idle(2);
        // MUL -7*9 with a held ADD request during the stall
        cycle(1'b1, 3'd6, 8'hF9, 8'd9, 3'd5);
        for (int i = 0; i < 10; i++) cycle(1'b1, 3'd0, 8'd1, 8'd2, 3'd4);
        run_idle(1);
        // MUL edge cases
        cycle(1'b1, 3'd6, 8'h80, 8'hFF, 3'd1); run_idle(9);
        cycle(1'b1, 3'd6, 8'd16, 8'd16, 3'd2); run_idle(9);
        cycle(1'b1, 3'd6, 8'd0, 8'h80, 3'd0); run_idle(9);

        // Reset three cycles into a MUL aborts it
        cycle(1'b1, 3'd6, 8'd3, 8'd3, 3'd6);
        run_idle(2);
        reset = 1'b1;
        #1;
        model_clear();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        run_idle(10);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  pick_operand(), pick_operand(), 3'($urandom_range(0, 7)));
        end
        run_idle(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
